// File: rtl/mem_writeback_ctrl.sv
// Writeback burst controller: streams NUM_ROWS staged 64-bit rows from the register
// bank into consecutive data-memory words, with a per-write ready timeout.
module mem_writeback_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int NUM_ROWS = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [63:0]       row_data_i,
  input  logic              dmem_ready_i,
  output logic              write_mem_o,
  output logic [3:0]        row_addr_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [63:0]       dmem_data_o,
  output logic              dmem_we_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROW_SEL = 2'd1,
    WRITE   = 2'd2,
    FIN     = 2'd3
  } state_e;

  localparam logic [1:0] LAST_ROW    = 2'(NUM_ROWS - 1);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e              state_q;
  logic [1:0]          row_q;
  logic [7:0]          wait_q;
  logic [ADDR_W-1:0]   base_q;
  logic                write_mem_q;
  logic [3:0]          row_addr_q;
  logic [ADDR_W-1:0]   dmem_addr_q;
  logic [63:0]         dmem_data_q;
  logic                dmem_we_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  // Handshake: dmem_we_o is a request that holds address and data stable until
  // dmem_ready_i is sampled high on a rising edge; the write completes on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= 2'd0;
      wait_q      <= 8'd0;
      base_q      <= '0;
      write_mem_q <= 1'b0;
      row_addr_q  <= 4'b0000;
      dmem_addr_q <= '0;
      dmem_data_q <= 64'd0;
      dmem_we_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            base_q      <= base_addr_i;
            row_q       <= 2'd0;
            err_q       <= 1'b0;
            write_mem_q <= 1'b1;
            row_addr_q  <= 4'b1000;
            busy_q      <= 1'b1;
            state_q     <= ROW_SEL;
          end else begin
            write_mem_q <= 1'b0;
            row_addr_q  <= 4'b0000;
            dmem_we_q   <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        ROW_SEL: begin
          // The bank has had the whole ROW_SEL cycle to return the selected row.
          dmem_data_q <= row_data_i;
          dmem_addr_q <= base_q + ADDR_W'(row_q);
          dmem_we_q   <= 1'b1;
          wait_q      <= 8'd0;
          state_q     <= WRITE;
        end
        WRITE: begin
          if (dmem_ready_i) begin
            dmem_we_q <= 1'b0;
            if (row_q == LAST_ROW) begin
              done_q      <= 1'b1;
              write_mem_q <= 1'b0;
              row_addr_q  <= 4'b0000;
              state_q     <= FIN;
            end else begin
              row_q      <= row_q + 2'd1;
              row_addr_q <= {2'b10, row_q + 2'd1};
              state_q    <= ROW_SEL;
            end
          end else begin
            wait_q <= wait_q + 8'd1;
            if (wait_q + 8'd1 == TIMEOUT_CNT) begin
              dmem_we_q   <= 1'b0;
              write_mem_q <= 1'b0;
              row_addr_q  <= 4'b0000;
              err_q       <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign write_mem_o = write_mem_q;
  assign row_addr_o  = row_addr_q;
  assign dmem_addr_o = dmem_addr_q;
  assign dmem_data_o = dmem_data_q;
  assign dmem_we_o   = dmem_we_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign state_o     = state_q;

endmodule
